// File: rtl/serial2d_pkg.sv
// Shared types and mode decoding for the 2D bit-serial MAC sequencer.
package serial2d_pkg;

   typedef enum logic [3:0] {
      MODE_8X8  = 4'b0000,
      MODE_A8W4 = 4'b0001,
      MODE_A8W2 = 4'b0011,
      MODE_4X4  = 4'b0111,
      MODE_2X2  = 4'b1111
   } mode_e;

   // m = activation bits, n = weight bits
   typedef struct packed {
      logic [3:0] m;
      logic [3:0] n;
   } mn_t;

   function automatic logic mode_legal(input logic [3:0] mode);
      logic ok;
      case (mode)
         MODE_8X8, MODE_A8W4, MODE_A8W2, MODE_4X4, MODE_2X2: ok = 1'b1;
         default:                                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic mn_t mode_to_mn(input logic [3:0] mode);
      mn_t r;
      case (mode)
         MODE_4X4:  r = '{m: 4'd4, n: 4'd4};
         MODE_2X2:  r = '{m: 4'd2, n: 4'd2};
         MODE_A8W4: r = '{m: 4'd8, n: 4'd4};
         MODE_A8W2: r = '{m: 4'd8, n: 4'd2};
         default:   r = '{m: 4'd8, n: 4'd8};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/serial2d_step_gen.sv
// Diagonal (i, j) step generator: walks the m x n bit-pair schedule and
// registers the per-step selects and flags so they appear one cycle after
// the load/advance decision.
module serial2d_step_gen
   import serial2d_pkg::*;
(
   input  logic       clk_fast,
   input  logic       rst,
   input  logic       load,
   input  logic       adv,
   input  mn_t        mn_in,
   output logic [2:0] a_sel,
   output logic [2:0] w_sel,
   output logic       shift_ctr,
   output logic       sign_ctr,
   output logic       rst_mult,
   output logic       final_step
);

   logic [3:0] i_q, i_n;
   logic [2:0] j_q, j_n;
   logic [3:0] m_q, m_n, n_q, n_n;
   logic       last_q;
   logic       act_n;
   logic [3:0] nm1, fin_i;
   logic [2:0] hi_n;
   logic       last_n, fin_n, sign_n;

   // Next step: the outputs are registered, so flags are evaluated on the
   // upcoming (i, j) rather than the one currently presented.
   always_comb begin
      m_n   = m_q;
      n_n   = n_q;
      i_n   = '0;
      j_n   = '0;
      act_n = 1'b0;
      if (load) begin
         m_n   = mn_in.m;
         n_n   = mn_in.n;
         act_n = 1'b1;
      end else if (adv) begin
         act_n = 1'b1;
         if (last_q) begin
            i_n = i_q + 4'd1;
            // first j of diagonal i+1 is max(0, i+2-m)
            if (({1'b0, i_q} + 5'd2) > {1'b0, m_q})
               j_n = 3'({1'b0, i_q} + 5'd2 - {1'b0, m_q});
            else
               j_n = '0;
         end else begin
            i_n = i_q;
            j_n = j_q + 3'd1;
         end
      end
      nm1    = n_n - 4'd1;
      fin_i  = m_n + n_n - 4'd2;
      hi_n   = (i_n < nm1) ? i_n[2:0] : nm1[2:0];
      sign_n = act_n && ({1'b0, j_n} == nm1);
      last_n = act_n && (j_n == hi_n);
      fin_n  = act_n && (i_n == fin_i) && ({1'b0, j_n} == nm1);
   end

   // Counter and output registers; idle presents zeros with rst_mult high.
   always_ff @(posedge clk_fast or posedge rst) begin
      if (rst) begin
         i_q        <= '0;
         j_q        <= '0;
         m_q        <= '0;
         n_q        <= '0;
         last_q     <= 1'b0;
         a_sel      <= '0;
         w_sel      <= '0;
         shift_ctr  <= 1'b0;
         sign_ctr   <= 1'b0;
         rst_mult   <= 1'b1;
         final_step <= 1'b0;
      end else begin
         i_q        <= i_n;
         j_q        <= j_n;
         m_q        <= m_n;
         n_q        <= n_n;
         last_q     <= last_n;
         a_sel      <= act_n ? 3'(i_n - {1'b0, j_n}) : 3'd0;
         w_sel      <= act_n ? j_n : 3'd0;
         shift_ctr  <= last_n && !fin_n;
         sign_ctr   <= sign_n;
         rst_mult   <= !act_n || fin_n;
         final_step <= fin_n;
      end
   end

endmodule

// File: rtl/serial2d_seq_ctrl.sv
// Sequencer for the 2D bit-serial MAC: valid/ready operand intake,
// IDLE/RUN control and operand latching around the step generator.
module serial2d_seq_ctrl
   import serial2d_pkg::*;
#(
   parameter int MAX_WIDTH = 8
) (
   input  logic                 clk_fast,
   input  logic                 rst,
   input  logic [3:0]           mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [MAX_WIDTH-1:0] w_in,
   input  logic [MAX_WIDTH-1:0] a_in,
   output logic [MAX_WIDTH-1:0] w,
   output logic [MAX_WIDTH-1:0] a,
   output logic [2:0]           a_sel,
   output logic [2:0]           w_sel,
   output logic                 shift_ctr,
   output logic                 sign_ctr,
   output logic                 rst_mult,
   output logic                 busy,
   output logic                 done,
   output logic                 mode_err
);

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e state_q, state_n;
   logic   final_step;
   logic   accept;
   logic   adv;

   assign mode_err = !mode_legal(mode);
   assign in_ready = ((state_q == S_IDLE) || final_step) && !mode_err;
   assign accept   = in_valid && in_ready;
   assign adv      = (state_q == S_RUN) && !final_step;
   assign busy     = (state_q == S_RUN);
   assign done     = final_step;

   serial2d_step_gen u_step_gen (
      .clk_fast   (clk_fast),
      .rst        (rst),
      .load       (accept),
      .adv        (adv),
      .mn_in      (mode_to_mn(mode)),
      .a_sel      (a_sel),
      .w_sel      (w_sel),
      .shift_ctr  (shift_ctr),
      .sign_ctr   (sign_ctr),
      .rst_mult   (rst_mult),
      .final_step (final_step)
   );

   // Next-state: an accept on the final step chains straight into a new run.
   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE: if (accept) state_n = S_RUN;
         S_RUN:  if (final_step && !accept) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_fast or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_n;
   end

   // Operand latch on accept; held otherwise.
   always_ff @(posedge clk_fast or posedge rst) begin
      if (rst) begin
         w <= '0;
         a <= '0;
      end else if (accept) begin
         w <= w_in;
         a <= a_in;
      end
   end

endmodule

// File: tb/tb_serial2d_seq_ctrl.sv
// Self-checking bench for serial2d_seq_ctrl against a schedule model built
// from nested diagonal loops.
module tb_serial2d_seq_ctrl;
   import serial2d_pkg::*;

   logic       clk_fast = 1'b0;
   logic       rst;
   logic [3:0] mode;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] w_in, a_in, w, a;
   logic [2:0] a_sel, w_sel;
   logic       shift_ctr, sign_ctr, rst_mult, busy, done, mode_err;

   int total = 0;
   int bad   = 0;

   localparam logic [10:0] IDLE_V = 11'b000_000_0_0_1_0_0;
   logic [10:0] dut_v;
   assign dut_v = {a_sel, w_sel, sign_ctr, shift_ctr, rst_mult, done, busy};

   serial2d_seq_ctrl #(.MAX_WIDTH(8)) dut (
      .clk_fast (clk_fast), .rst (rst), .mode (mode), .in_valid (in_valid),
      .in_ready (in_ready), .w_in (w_in), .a_in (a_in), .w (w), .a (a),
      .a_sel (a_sel), .w_sel (w_sel), .shift_ctr (shift_ctr),
      .sign_ctr (sign_ctr), .rst_mult (rst_mult), .busy (busy),
      .done (done), .mode_err (mode_err)
   );

   always #5 clk_fast = ~clk_fast;

   function automatic void bench_mn(input logic [3:0] md, output int m, output int n);
      case (md)
         4'b0000: begin m = 8; n = 8; end
         4'b0111: begin m = 4; n = 4; end
         4'b1111: begin m = 2; n = 2; end
         4'b0001: begin m = 8; n = 4; end
         default: begin m = 8; n = 2; end
      endcase
   endfunction

   // Expected {a_sel, w_sel, sign, shift, rst_mult, done, busy} for step k.
   function automatic logic [10:0] exp_step(input int m, input int n, input int k);
      int cnt;
      int lo, hi;
      logic fin;
      logic [10:0] v;
      cnt = 0;
      v   = '0;
      for (int i = 0; i <= m + n - 2; i++) begin
         lo = (i - m + 1 > 0) ? i - m + 1 : 0;
         hi = (i < n - 1) ? i : n - 1;
         for (int j = lo; j <= hi; j++) begin
            if (cnt == k) begin
               fin = (i == m + n - 2) && (j == n - 1);
               v = {3'(i - j), 3'(j), (j == n - 1), (j == hi) && !fin, fin, fin, 1'b1};
            end
            cnt++;
         end
      end
      return v;
   endfunction

   task automatic tick;
      @(posedge clk_fast);
      #1;
   endtask

   task automatic start_op(input logic [3:0] md, input logic [7:0] wv, input logic [7:0] av);
      mode = md; w_in = wv; a_in = av; in_valid = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL start_ready: in_ready=%b required 1", in_ready);
      end
      tick;
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      total++;
      if (dut_v !== IDLE_V) begin
         bad++; $display("FAIL reset_outputs: got %b required %b", dut_v, IDLE_V);
      end
      total++;
      if (w !== 8'h00 || a !== 8'h00) begin
         bad++; $display("FAIL reset_operands: w=%h a=%h required 00 00", w, a);
      end
      total++;
      if (in_ready !== 1'b1 || mode_err !== 1'b0) begin
         bad++; $display("FAIL reset_ready: in_ready=%b mode_err=%b required 1 0", in_ready, mode_err);
      end
   endtask

   task automatic test_2x2;
      logic [10:0] e;
      start_op(4'b1111, 8'hC0, 8'h80);
      for (int k = 0; k < 4; k++) begin
         e = exp_step(2, 2, k);
         total++;
         if (dut_v !== e) begin
            bad++; $display("FAIL 2x2_step%0d: got %b required %b", k, dut_v, e);
         end
         if (k == 0) begin
            total++;
            if (w !== 8'hC0 || a !== 8'h80) begin
               bad++; $display("FAIL 2x2_operands: w=%h a=%h required c0 80", w, a);
            end
         end
         if (k < 3) tick;
      end
      tick;
      total++;
      if (dut_v !== IDLE_V) begin
         bad++; $display("FAIL 2x2_idle: got %b required %b", dut_v, IDLE_V);
      end
   endtask

   task automatic test_8x8;
      logic [10:0] e;
      int sgn, shf, run;
      sgn = 0; shf = 0; run = 0;
      start_op(4'b0000, 8'($urandom), 8'($urandom));
      for (int k = 0; k < 64; k++) begin
         e = exp_step(8, 8, k);
         total++;
         if (dut_v !== e) begin
            bad++; $display("FAIL 8x8_step%0d: got %b required %b", k, dut_v, e);
         end
         sgn += int'(sign_ctr);
         shf += int'(shift_ctr);
         run += int'(busy);
         tick;
      end
      total++;
      if (dut_v !== IDLE_V) begin
         bad++; $display("FAIL 8x8_idle: got %b required %b", dut_v, IDLE_V);
      end
      total++;
      if (sgn != 8 || shf != 14 || run != 64) begin
         bad++; $display("FAIL 8x8_counts: sign=%0d shift=%0d busy=%0d required 8 14 64", sgn, shf, run);
      end
   endtask

   task automatic test_back_to_back;
      logic [10:0] e;
      logic [7:0]  w1, a1, w2, a2;
      w1 = 8'($urandom); a1 = 8'($urandom);
      w2 = ~w1;          a2 = 8'($urandom);
      mode = 4'b0011; w_in = w1; a_in = a1; in_valid = 1'b1;
      #1;
      tick;
      w_in = w2; a_in = a2;
      for (int k = 0; k < 16; k++) begin
         e = exp_step(8, 2, k);
         total++;
         if (dut_v !== e || in_ready !== (k == 15) || w !== w1 || a !== a1) begin
            bad++;
            $display("FAIL b2b_op1_step%0d: v=%b rdy=%b w=%h a=%h required v=%b rdy=%b w=%h a=%h",
                     k, dut_v, in_ready, w, a, e, (k == 15), w1, a1);
         end
         if (k < 15) tick;
      end
      tick;
      in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         e = exp_step(8, 2, k);
         total++;
         if (dut_v !== e || w !== w2 || a !== a2) begin
            bad++;
            $display("FAIL b2b_op2_step%0d: v=%b w=%h a=%h required v=%b w=%h a=%h",
                     k, dut_v, w, a, e, w2, a2);
         end
         if (k < 15) tick;
      end
      tick;
      total++;
      if (dut_v !== IDLE_V) begin
         bad++; $display("FAIL b2b_idle: got %b required %b", dut_v, IDLE_V);
      end
   endtask

   task automatic test_mode_change;
      logic [10:0] e;
      start_op(4'b0001, 8'($urandom), 8'($urandom));
      for (int k = 0; k < 32; k++) begin
         if (k == 5) mode = 4'b1111;
         e = exp_step(8, 4, k);
         total++;
         if (dut_v !== e) begin
            bad++; $display("FAIL modechg_step%0d: got %b required %b", k, dut_v, e);
         end
         tick;
      end
      total++;
      if (dut_v !== IDLE_V) begin
         bad++; $display("FAIL modechg_idle: got %b required %b", dut_v, IDLE_V);
      end
      mode = 4'b0000;
   endtask

   task automatic test_reset_mid;
      logic [10:0] e;
      start_op(4'b0000, 8'hA5, 8'h5A);
      for (int k = 0; k < 10; k++) begin
         e = exp_step(8, 8, k);
         total++;
         if (dut_v !== e) begin
            bad++; $display("FAIL rstmid_step%0d: got %b required %b", k, dut_v, e);
         end
         tick;
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (dut_v !== IDLE_V || w !== 8'h00 || a !== 8'h00) begin
         bad++; $display("FAIL rstmid_async: v=%b w=%h a=%h required %b 00 00", dut_v, w, a, IDLE_V);
      end
      for (int c = 0; c < 3; c++) begin
         tick;
         total++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_hold%0d: done=%b busy=%b required 0 0", c, done, busy);
         end
      end
      #2 rst = 1'b0;
      tick;
      start_op(4'b1111, 8'($urandom), 8'($urandom));
      for (int k = 0; k < 4; k++) begin
         e = exp_step(2, 2, k);
         total++;
         if (dut_v !== e) begin
            bad++; $display("FAIL rstmid_restart%0d: got %b required %b", k, dut_v, e);
         end
         tick;
      end
   endtask

   task automatic test_illegal;
      mode = 4'b0101; in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick;
         total++;
         if (mode_err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL illegal_c%0d: err=%b rdy=%b busy=%b required 1 0 0",
                            c, mode_err, in_ready, busy);
         end
      end
      in_valid = 1'b0; mode = 4'b0000;
      tick;
   endtask

   task automatic test_random;
      logic [3:0]  modes [5];
      logic [3:0]  md;
      logic [7:0]  wv, av;
      logic [10:0] e;
      int m, n;
      modes = '{MODE_8X8, MODE_4X4, MODE_2X2, MODE_A8W4, MODE_A8W2};
      for (int op = 0; op < 6; op++) begin
         md = modes[$urandom_range(0, 4)];
         wv = 8'($urandom); av = 8'($urandom);
         bench_mn(md, m, n);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick;
         start_op(md, wv, av);
         for (int k = 0; k < m * n; k++) begin
            e = exp_step(m, n, k);
            total++;
            if (dut_v !== e || w !== wv || a !== av) begin
               bad++;
               $display("FAIL rand_op%0d_mode%b_step%0d: v=%b w=%h a=%h required %b %h %h",
                        op, md, k, dut_v, w, a, e, wv, av);
            end
            tick;
         end
         total++;
         if (dut_v !== IDLE_V) begin
            bad++; $display("FAIL rand_idle%0d: got %b required %b", op, dut_v, IDLE_V);
         end
      end
   endtask

   initial begin
      rst = 1'b1; mode = 4'b0000; in_valid = 1'b0; w_in = '0; a_in = '0;
      #12;
      test_reset;
      rst = 1'b0;
      tick;
      test_2x2;
      test_8x8;
      test_back_to_back;
      test_mode_change;
      test_reset_mid;
      test_illegal;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
